mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 mux output channel between four requesters (a, b, c, d). It owns the mux select lines (s1, s0), grants one requester at a time and moves that requester's data to a single valid/ready output. It holds a grant for a bounded burst, then rotates priority. It sits in front of any downstream consumer that can accept only one source at a time.

---
 rtl/mux4_rr_arbiter_pkg.sv | 33 +++
 rtl/mux4_rr_arbiter_if.sv | 40 ++++
 rtl/mux4_rr_arbiter_rr_pick.sv | 35 +++
 rtl/mux_4_1.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 225 ++++++++++++++++++++++
 6 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4_arb_pkg
// Description : Shared constants, FSM state encoding and the helper that
//               turns a rotated one-hot winner back into a requester index.
// Revision    : 1.0 - initial release
// ============================================================================
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    // Arbiter FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t c_idle = 1'b0;
    localparam state_t c_busy = 1'b1;

    // The one-hot is relative to the priority pointer (bit 0 == ptr), so the
    // absolute index is its bit position plus ptr, wrapping modulo NUM_REQ.
    function automatic logic [SEL_W-1:0] rot_onehot_to_idx(
        input logic [NUM_REQ-1:0] onehot,
        input logic [SEL_W-1:0]   ptr
    );
        logic [SEL_W-1:0] pos;
        pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) pos = SEL_W'(i);
        end
        return pos + ptr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter_if
// Description : Requester / consumer bundle of the 4:1 round-robin arbiter.
//               master : requesters + downstream consumer side
//                        (drives req, in_a..in_d, out_ready)
//               slave  : arbiter side
//                        (drives out_data, out_valid, ack, grant, s1, s0)
// Revision    : 1.0 - initial release
// ============================================================================
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    import mux4_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [WIDTH-1:0]   in_c;
    logic [WIDTH-1:0]   in_d;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] grant;
    logic               s1;
    logic               s0;

    modport master (
        output req, in_a, in_b, in_c, in_d, out_ready,
        input  out_data, out_valid, ack, grant, s1, s0
    );

    modport slave (
        input  req, in_a, in_b, in_c, in_d, out_ready,
        output out_data, out_valid, ack, grant, s1, s0
    );

endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Finds the first set bit of
//               req searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//               Ports: req request vector, ptr priority pointer,
//                      found any request set, idx winning index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mux4_arb_pkg::*;
(
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [SEL_W-1:0]   ptr,
    output logic                    found,
    output logic [SEL_W-1:0]        idx
);

    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_first;

    always_comb begin
        w_rot = '0;
        // Rotate so that bit 0 of w_rot is the requester at ptr
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rot[i] = req[SEL_W'(i) + ptr];
        end
        // Isolate the lowest set bit: highest priority after the pointer
        w_first = w_rot & (~w_rot + NUM_REQ'(1));
        found   = |req;
        idx     = rot_onehot_to_idx(w_first, ptr);
    end

endmodule
`default_nettype wire

// File: rtl/mux_4_1.sv
`default_nettype none
// ============================================================================
// Module      : mux_4_1
// Description : Single-bit 4:1 multiplexer, select = {i_s1, i_s0}.
//               Ports: i_a..i_d data in, i_s0/i_s1 select, o_y data out.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4_1 (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_c,
    input  wire logic i_d,
    input  wire logic i_s0,
    input  wire logic i_s1,
    output logic      o_y
);

    always_comb begin
        case ({i_s1, i_s0})
            2'b00:   o_y = i_a;
            2'b01:   o_y = i_b;
            2'b10:   o_y = i_c;
            default: o_y = i_d;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter owning the select lines of a 4:1 mux.
//               Grants one requester at a time, forwards its data through a
//               valid/ready output and rotates after MAX_HOLD accepted beats
//               or when the granted requester withdraws.
//               Ports: clk, rst (sync, active-high), bus (slave modport:
//                      req, in_a..in_d, out_ready in; out_data, out_valid,
//                      ack, grant, s1, s0 out).
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4     // legal 1..15
)(
    input  wire logic         clk,
    input  wire logic         rst,
    mux4_rr_arbiter_if.slave  bus
);

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [SEL_W-1:0]   r_sel,   w_sel_nxt;
    logic [SEL_W-1:0]   r_ptr,   w_ptr_nxt;
    logic [3:0]         r_cnt,   w_cnt_nxt;

    logic               w_valid;
    logic               w_accept;
    logic               w_last;
    logic               w_release;
    logic [SEL_W-1:0]   w_pick_ptr;
    logic               w_found;
    logic [SEL_W-1:0]   w_pick_idx;
    logic [SEL_W-1:0]   w_mux_sel;
    logic [WIDTH-1:0]   w_data;

    // While busy, r_sel holds the granted index, so a release re-arbitrates
    // from g+1 in the same edge and avoids a bubble cycle.
    assign w_pick_ptr = (r_state == c_busy) ? r_sel + SEL_W'(1) : r_ptr;

    rr_pick u_pick (
        .req   (bus.req),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    assign w_valid   = (r_state == c_busy) && bus.req[r_sel] && !rst;
    assign w_accept  = w_valid && bus.out_ready;
    assign w_last    = (int'(r_cnt) + 1) >= MAX_HOLD;
    // Release on the last beat of a burst, or when the holder withdraws
    assign w_release = (r_state == c_busy) &&
                       (w_accept ? w_last : !bus.req[r_sel]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_idle: begin
                if (w_found) begin
                    w_state_nxt = c_busy;
                    w_grant_nxt = NUM_REQ'(1) << w_pick_idx;
                    w_sel_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            c_busy: begin
                if (w_release) begin
                    w_ptr_nxt = r_sel + SEL_W'(1);
                    if (w_found) begin
                        w_grant_nxt = NUM_REQ'(1) << w_pick_idx;
                        w_sel_nxt   = w_pick_idx;
                        w_cnt_nxt   = '0;
                    end else begin
                        // Select lines keep their last value while idle
                        w_state_nxt = c_idle;
                        w_grant_nxt = '0;
                    end
                end else if (w_accept) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Forcing select 0 during reset presents in_a before the first edge too
    assign w_mux_sel = rst ? '0 : r_sel;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            mux_4_1 u_mux (
                .i_a  (bus.in_a[i]),
                .i_b  (bus.in_b[i]),
                .i_c  (bus.in_c[i]),
                .i_d  (bus.in_d[i]),
                .i_s0 (w_mux_sel[0]),
                .i_s1 (w_mux_sel[1]),
                .o_y  (w_data[i])
            );
        end
    endgenerate

    assign bus.out_data  = w_data;
    assign bus.out_valid = w_valid;
    assign bus.ack       = w_accept ? r_grant : '0;
    assign bus.grant     = r_grant;
    assign bus.s1        = r_sel[1];
    assign bus.s0        = r_sel[0];

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Self-checking bench. Two arbiters (MAX_HOLD=4 and 1) share
//               one directed stimulus stream; a behavioural model tracks
//               each and is compared every cycle, with literal expectations
//               at the key points of every scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] in_a, in_b, in_c, in_d;
    logic       ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.WIDTH(8)) if0 ();
    mux4_rr_arbiter_if #(.WIDTH(8)) if1 ();

    assign if0.req = req;  assign if1.req = req;
    assign if0.in_a = in_a; assign if1.in_a = in_a;
    assign if0.in_b = in_b; assign if1.in_b = in_b;
    assign if0.in_c = in_c; assign if1.in_c = in_c;
    assign if0.in_d = in_d; assign if1.in_d = in_d;
    assign if0.out_ready = ready; assign if1.out_ready = ready;

    mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  hold   [2] = '{4, 1};
    bit  m_busy [2];
    int  m_g    [2];
    int  m_sel  [2];
    int  m_ptr  [2];
    int  m_cnt  [2];
    bit  m_init = 0;
    bit  m_rel;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 0; m_g[d] = 0; m_sel[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
                m_init = 1;
            end else if (!m_busy[d]) begin
                if (req != 0) begin
                    m_g[d] = pick(req, m_ptr[d]); m_sel[d] = m_g[d];
                    m_busy[d] = 1; m_cnt[d] = 0;
                end
            end else begin
                m_rel = 0;
                if (req[m_g[d]] && ready) begin
                    if (m_cnt[d] + 1 < hold[d]) m_cnt[d]++;
                    else m_rel = 1;
                end else if (!req[m_g[d]]) begin
                    m_rel = 1;
                end
                if (m_rel) begin
                    m_ptr[d] = (m_g[d] + 1) % 4;
                    if (req != 0) begin
                        m_g[d] = pick(req, m_ptr[d]); m_sel[d] = m_g[d]; m_cnt[d] = 0;
                    end else begin
                        m_busy[d] = 0;
                    end
                end
            end
        end
    end

    function automatic logic [3:0] m_grant(input int d);
        return m_busy[d] ? (4'(1) << m_g[d]) : 4'b0000;
    endfunction

    function automatic logic m_valid(input int d);
        return m_busy[d] && req[m_g[d]] && !rst;
    endfunction

    function automatic logic [7:0] m_data(input int d);
        if (rst) return in_a;
        case (m_sel[d])
            0: return in_a;
            1: return in_b;
            2: return in_c;
            default: return in_d;
        endcase
    endfunction

    task automatic cmp_dut(input int d, input logic [3:0] gnt, input logic vld,
                           input logic [3:0] ak, input logic [1:0] sel, input logic [7:0] dat);
        logic [3:0] eack;
        eack = (m_valid(d) && ready) ? m_grant(d) : 4'b0000;
        chk($sformatf("dut%0d grant", d), 32'(gnt), 32'(m_grant(d)));
        chk($sformatf("dut%0d valid", d), 32'(vld), 32'(m_valid(d)));
        chk($sformatf("dut%0d ack", d),   32'(ak),  32'(eack));
        chk($sformatf("dut%0d sel", d),   32'(sel), 32'(m_sel[d]));
        chk($sformatf("dut%0d data", d),  32'(dat), 32'(m_data(d)));
    endtask

    always @(negedge clk) begin
        #2;
        if (m_init) begin
            cmp_dut(0, if0.grant, if0.out_valid, if0.ack, {if0.s1, if0.s0}, if0.out_data);
            cmp_dut(1, if1.grant, if1.out_valid, if1.ack, {if1.s1, if1.s0}, if1.out_data);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset();
        @(negedge clk); rst = 1'b1; req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_g;
        rst = 1'b1; req = 4'b1111; ready = 1'b1;
        in_a = 8'hA0; in_b = 8'hB1; in_c = 8'hC2; in_d = 8'hD3;

        // Reset held with all requests high
        @(negedge clk); #1;
        chk("rst grant", 32'(if0.grant), 32'h0);
        chk("rst valid", 32'(if0.out_valid), 32'h0);
        chk("rst ack",   32'(if0.ack), 32'h0);
        chk("rst sel",   32'({if0.s1, if0.s0}), 32'h0);
        chk("rst data",  32'(if0.out_data), 32'hA0);
        chk("rst valid1", 32'(if1.out_valid), 32'h0);
        @(negedge clk); rst = 1'b0;

        // Fairness on the one-beat arbiter, first grant a on both
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            exp_g = 4'b0001 << (k % 4);
            chk("fair grant", 32'(if1.grant), 32'(exp_g));
            chk("fair ack",   32'(if1.ack), 32'(exp_g));
            chk("fair model", 32'(m_grant(1)), 32'(exp_g));
            if (k == 0) begin
                chk("first grant a", 32'(if0.grant), 32'h1);
                chk("first data a",  32'(if0.out_data), 32'hA0);
            end
        end

        // Single requester c, bursts back to back with no bubble
        do_reset();
        rst = 1'b0; req = 4'b0100; in_c = 8'h5A; ready = 1'b1;
        @(negedge clk); #1;
        chk("single grant", 32'(if0.grant), 32'h4);
        chk("single sel",   32'({if0.s1, if0.s0}), 32'h2);
        chk("single data",  32'(if0.out_data), 32'h5A);
        chk("single ack0",  32'(if0.ack), 32'h4);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk); #1;
            chk("single ack",   32'(if0.ack), 32'h4);
            chk("single grant", 32'(if0.grant), 32'h4);
        end

        // Backpressure on a, then 4 beats, then rotate to b
        do_reset();
        rst = 1'b0; req = 4'b0011; ready = 1'b0; in_c = 8'hC2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp grant", 32'(if0.grant), 32'h1);
            chk("bp ack",   32'(if0.ack), 32'h0);
            chk("bp data",  32'(if0.out_data), 32'hA0);
        end
        ready = 1'b1; #1;
        chk("bp beat1", 32'(if0.ack), 32'h1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); #1;
            chk("bp beat", 32'(if0.ack), 32'h1);
        end
        @(negedge clk); #1;
        chk("bp rotate grant", 32'(if0.grant), 32'h2);
        chk("bp rotate ack",   32'(if0.ack), 32'h2);

        // Withdrawal of b before accept, d granted next
        do_reset();
        rst = 1'b0; req = 4'b0010; ready = 1'b0;
        @(negedge clk); #1;
        chk("wd grant b", 32'(if0.grant), 32'h2);
        req = 4'b1000; #1;
        chk("wd ack",   32'(if0.ack), 32'h0);
        chk("wd valid", 32'(if0.out_valid), 32'h0);
        @(negedge clk); #1;
        chk("wd grant d", 32'(if0.grant), 32'h8);

        // Reset during b's second beat
        do_reset();
        rst = 1'b0; req = 4'b0010; ready = 1'b1;
        @(negedge clk); #1;
        chk("mid beat1", 32'(if0.ack), 32'h2);
        @(negedge clk); rst = 1'b1; #1;
        chk("mid ack",   32'(if0.ack), 32'h0);
        chk("mid valid", 32'(if0.out_valid), 32'h0);
        @(negedge clk); rst = 1'b0; req = 4'b0011; #1;
        chk("mid idle", 32'(if0.grant), 32'h0);
        @(negedge clk); #1;
        chk("mid grant a", 32'(if0.grant), 32'h1);

        repeat (3) @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
